demux_viii_deser: RTL and testbench

Serial-to-parallel 1:8 deserializer. A 3-bit write index steers each incoming serial bit into one bit position of an 8-bit assembly register; the index sweeps 0..7 and then wraps. It is the receiving end of the 8:1 bit-select path: an 8:1 mux driven by a counter serializes a byte, and this block rebuilds that byte and presents it as a registered parallel word with a one-cycle valid strobe.

---
 rtl/demux_viii_deser.sv | 75 +++++++
 tb/tb_demux_viii_deser.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/demux_viii_deser.sv
// demux_viii_deser: 1:8 serial-to-parallel deserializer with registered byte and one-cycle valid strobe.
// Define DESER_PARITY_EN to expect a trailing even-parity bit per byte and report parity_err.
module demux_viii_deser #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       busy,
  output logic [2:0] select_idx,
  output logic       parity_err
);
`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
  typedef enum logic {IDLE, RECV} state_t;
`endif
  state_t r_state, w_next;
  logic [7:0] r_asm, w_asm;
  logic [2:0] w_pos;
  logic w_acc, w_last, w_data, w_done;
  assign w_acc  = bit_valid & ~clear;
  assign w_last = w_acc && select_idx == 3'd7;
  assign w_pos  = LSB_FIRST ? select_idx : 3'd7 - select_idx;
  assign busy   = r_state != IDLE;
`ifdef DESER_PARITY_EN
  assign w_data = w_acc && r_state != PAR;
  assign w_done = w_acc && r_state == PAR;
`else
  assign w_data = w_acc;
  assign w_done = w_last;
  assign parity_err = 1'b0;
`endif
  always_comb begin
    w_asm = r_asm;
    w_asm[w_pos] = bit_in;
  end
  always_comb begin
`ifdef DESER_PARITY_EN
    w_next = clear ? IDLE : !bit_valid ? r_state : r_state == PAR ? IDLE : w_last ? PAR : RECV;
`else
    w_next = clear ? IDLE : !bit_valid ? r_state : w_last ? IDLE : RECV;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_asm      <= 8'h00;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      select_idx <= 3'd0;
`ifdef DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      byte_valid <= w_done;
      if (clear) select_idx <= 3'd0;
      else if (w_data) select_idx <= select_idx + 3'd1;
      if (w_data) r_asm <= w_asm;
`ifdef DESER_PARITY_EN
      // data is already complete in r_asm; the accepted bit is the parity bit
      if (w_done) byte_out <= r_asm;
      if (w_done) parity_err <= (^r_asm) ^ bit_in;
`else
      if (w_done) byte_out <= w_asm;
`endif
    end
  end
endmodule

// File: tb/tb_demux_viii_deser.sv
// tb_demux_viii_deser: directed stimulus with expected-byte scoreboard for both bit orders.
module tb_demux_viii_deser;
  logic clk = 1'b0, reset, clear, bit_in, bit_valid;
  logic [7:0] o0, o1;
  logic v0, v1, b0, b1, p0, p1;
  logic [2:0] s0, s1;
  int errors = 0, checks = 0, cyc = 0, last_cyc = 0, prev_cyc = 0;
  logic [8:0] q0[$], q1[$];
`ifdef DESER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  demux_viii_deser #(.LSB_FIRST(1'b1)) dut0 (.clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .byte_out(o0), .byte_valid(v0), .busy(b0), .select_idx(s0), .parity_err(p0));
  demux_viii_deser #(.LSB_FIRST(1'b0)) dut1 (.clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .byte_out(o1), .byte_valid(v1), .busy(b1), .select_idx(s1), .parity_err(p1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev[i] = v[7-i];
  endfunction

  function automatic logic exp_perr(input logic [7:0] v, input logic p);
`ifdef DESER_PARITY_EN
    return (^v) ^ p;
`else
    return 1'b0;
`endif
  endfunction

  // scoreboard: every strobe must match the oldest outstanding frame
  always @(negedge clk) if (!reset) begin
    logic [8:0] e;
    if (v0) begin
      chk("valid0_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("byte0", o0, e[7:0]);
        chk("perr0", p0, e[8]);
      end
      prev_cyc = last_cyc;
      last_cyc = cyc;
    end
    if (v1) begin
      chk("valid1_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("byte1", o1, e[7:0]);
        chk("perr1", p1, e[8]);
      end
    end
  end

  task automatic send(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1 bit_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic p, input int gap);
    for (int i = 0; i < 8; i++) begin
      if (i == 5 && gap > 0) begin
        chk("gap_idx_before", s0, 5);
        repeat (gap) @(posedge clk);
        #1 chk("gap_idx_frozen", s0, 5);
        chk("gap_busy", b0, 1);
      end
      send(v[i]);
    end
`ifdef DESER_PARITY_EN
    send(p);
`endif
    q0.push_back({exp_perr(v, p), v});
    q1.push_back({exp_perr(v, p), rev(v)});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte"}, o0, 0);
    chk({tag, "_valid"}, v0, 0);
    chk({tag, "_busy"}, b0, 0);
    chk({tag, "_idx"}, s0, 0);
    chk({tag, "_perr"}, p0, 0);
    chk({tag, "_byte1"}, o1, 0);
  endtask

  initial begin
    logic [7:0] ob;
    reset = 1'b1; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    reset = 1'b0;
    send_frame(8'hA5, 1'b0, 0);
    @(negedge clk);
    chk("a5_valid0", v0, 1);
    chk("a5_valid1", v1, 1);
    chk("a5_busy_fall", b0, 0);
    @(negedge clk);
    chk("a5_valid_pulse_end", v0, 0);
    send_frame(8'hA5, 1'b1, 0);
    repeat (4) @(negedge clk);
    chk("perr_held", p0, exp_perr(8'hA5, 1'b1));
    send_frame(8'h03, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("lsb0_03", o1, 8'hC0);
    send_frame(8'h3C, 1'b0, 0);
    chk("wrap_idx", s0, 0);
    send_frame(8'hFF, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("b2b_spacing", last_cyc - prev_cyc, FL);
    send_frame(8'h5A, 1'b0, 10);
    repeat (3) @(negedge clk);
    ob = o0;
    for (int i = 0; i < 5; i++) send(1'b1);
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; bit_valid = 1'b0;
    chk("clr_idx", s0, 0);
    chk("clr_busy", b0, 0);
    chk("clr_byte", o0, ob);
    @(negedge clk);
    chk("clr_no_valid", v0, 0);
    for (int i = 0; i < 7; i++) send(1'b0);
    chk("clr7_idx_before", s0, 7);
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    @(posedge clk);
    #1 clear = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    chk("clr7_no_valid", v0, 0);
    chk("clr7_byte", o0, ob);
    chk("clr7_idx", s0, 0);
    send_frame(8'hC3, 1'b1, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) send(1'b1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    reset = 1'b0;
    send_frame(8'h96, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
